alu_operand_adder: RTL and testbench

Registered EX-stage operand-select and 64-bit add/subtract unit for the RV64 pipeline.
- Operand A is selected between the forwarded rs1 value and the PC.
- Operand B is selected among the forwarded rs2 value, the immediate, constant 4, and zero.
- A 64-bit adder produces the sum or difference plus overflow/sign/cout/carry/zero flags.
- Results are registered once, so downstream compare/branch/SLT logic consumes them one cycle later.

---
 rtl/alu_operand_adder_if.sv | 38 +++
 rtl/alu_operand_adder.sv | 68 ++++++
 tb/tb_alu_operand_adder.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_adder_if.sv
// alu_operand_adder_if
//   Bundles the EX-stage operand/adder signals for alu_operand_adder.
//   master : pipeline side, drives operands and controls, observes results
//   slave  : adder unit, consumes operands and controls, drives results
//   Inputs  : in_valid, sub, alu_op1_src, alu_op2_src, rs1_data, rs2_data, pc, imm
//   Outputs : out_valid, op1, op2, result, overflow, sign, cout, carry, zero
interface alu_operand_adder_if #(
   parameter int XLEN = 64
);
   logic            in_valid;
   logic            sub;
   logic            alu_op1_src;
   logic [1:0]      alu_op2_src;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] imm;

   logic            out_valid;
   logic [XLEN-1:0] op1;
   logic [XLEN-1:0] op2;
   logic [XLEN-1:0] result;
   logic            overflow;
   logic            sign;
   logic            cout;
   logic            carry;
   logic            zero;

   modport master (
      output in_valid, sub, alu_op1_src, alu_op2_src, rs1_data, rs2_data, pc, imm,
      input  out_valid, op1, op2, result, overflow, sign, cout, carry, zero
   );

   modport slave (
      input  in_valid, sub, alu_op1_src, alu_op2_src, rs1_data, rs2_data, pc, imm,
      output out_valid, op1, op2, result, overflow, sign, cout, carry, zero
   );
endinterface

// File: rtl/alu_operand_adder.sv
// alu_operand_adder
//   Registered EX-stage operand select and XLEN-bit add/subtract unit.
//   Operand A is rs1_data or pc; operand B is rs2_data, imm, 4 or 0.
//   Sum/difference and flags are registered once (1-cycle latency).
//   Ports:
//     clk : rising-edge clock
//     rst : synchronous active-high reset, clears every output register
//     bus : alu_operand_adder_if slave modport (operands in, results out)
module alu_operand_adder #(
   parameter int XLEN = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   alu_operand_adder_if.slave   bus
);

   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b_sel;
   logic [XLEN-1:0] b;
   logic [XLEN:0]   sum;
   logic [XLEN-1:0] s;
   logic            c64;
   logic            ovf;

   always_comb begin
      a = bus.alu_op1_src ? bus.pc : bus.rs1_data;
      b_sel = '0;
      unique case (bus.alu_op2_src)
         2'b00:   b_sel = bus.rs2_data;
         2'b01:   b_sel = bus.imm;
         2'b10:   b_sel = XLEN'(4);
         default: b_sel = '0;
      endcase
      // Subtract as a + ~b + 1; carry-in is the sub bit itself.
      b   = bus.sub ? ~b_sel : b_sel;
      sum = {1'b0, a} + {1'b0, b} + {{XLEN{1'b0}}, bus.sub};
      s   = sum[XLEN-1:0];
      c64 = sum[XLEN];
      // Signed overflow is judged on the operand actually fed to the adder.
      ovf = (a[XLEN-1] == b[XLEN-1]) && (s[XLEN-1] != a[XLEN-1]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.op1       <= '0;
         bus.op2       <= '0;
         bus.result    <= '0;
         bus.overflow  <= 1'b0;
         bus.sign      <= 1'b0;
         bus.cout      <= 1'b0;
         bus.carry     <= 1'b0;
         bus.zero      <= 1'b0;
      end else begin
         bus.out_valid <= bus.in_valid;
         bus.op1       <= a;
         bus.op2       <= b_sel;
         bus.result    <= s;
         bus.overflow  <= ovf;
         bus.sign      <= s[XLEN-1];
         bus.cout      <= c64;
         // For subtract, no carry out means a borrow (op1 <u op2).
         bus.carry     <= c64 ^ bus.sub;
         bus.zero      <= (s == '0);
      end
   end

endmodule

// File: tb/tb_alu_operand_adder.sv
module tb_alu_operand_adder;

   typedef struct packed {
      logic        vld;
      logic [63:0] op1;
      logic [63:0] op2;
      logic [63:0] res;
      logic [4:0]  fl;   // {overflow, sign, cout, carry, zero}
   } exp_t;

   logic clk;
   logic rst;
   int   passed;
   int   failed;
   int   total;
   exp_t scb[$];

   alu_operand_adder_if #(.XLEN(64)) bus ();

   alu_operand_adder #(.XLEN(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model written from the arithmetic meaning, not the adder structure.
   function automatic exp_t model(input logic r, input logic v, input logic sb_in,
                                  input logic s1, input logic [1:0] s2,
                                  input logic [63:0] x1, input logic [63:0] x2,
                                  input logic [63:0] p, input logic [63:0] im);
      exp_t e;
      logic [63:0] a, bs, res;
      logic [64:0] wide;
      logic signed [64:0] sw;
      logic ov, co, ca;
      e = '0;
      if (r) return e;
      a = s1 ? p : x1;
      case (s2)
         2'b00: bs = x2;
         2'b01: bs = im;
         2'b10: bs = 64'd4;
         default: bs = 64'd0;
      endcase
      if (sb_in) begin
         res = a - bs;
         ca  = (a < bs);
         co  = !ca;
         sw  = $signed({a[63], a}) - $signed({bs[63], bs});
      end else begin
         wide = {1'b0, a} + {1'b0, bs};
         res  = wide[63:0];
         co   = wide[64];
         ca   = co;
         sw   = $signed({a[63], a}) + $signed({bs[63], bs});
      end
      ov    = (sw[64] != sw[63]);
      e.vld = v;
      e.op1 = a;
      e.op2 = bs;
      e.res = res;
      e.fl  = {ov, res[63], co, ca, (res == 64'd0)};
      return e;
   endfunction

   task automatic tick(input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      if (scb.size() == 0) begin
         chk({tag, "_scb_empty"}, 64'd1, 64'd0);
      end else begin
         e = scb.pop_front();
         chk({tag, "_valid"}, 64'(bus.out_valid), 64'(e.vld));
         chk({tag, "_op1"}, bus.op1, e.op1);
         chk({tag, "_op2"}, bus.op2, e.op2);
         chk({tag, "_result"}, bus.result, e.res);
         chk({tag, "_flags"}, 64'({bus.overflow, bus.sign, bus.cout, bus.carry, bus.zero}),
             64'(e.fl));
      end
   endtask

   task automatic step(input string tag, input logic r, input logic v, input logic sb_in,
                       input logic s1, input logic [1:0] s2,
                       input logic [63:0] x1, input logic [63:0] x2,
                       input logic [63:0] p, input logic [63:0] im);
      rst              = r;
      bus.in_valid     = v;
      bus.sub          = sb_in;
      bus.alu_op1_src  = s1;
      bus.alu_op2_src  = s2;
      bus.rs1_data     = x1;
      bus.rs2_data     = x2;
      bus.pc           = p;
      bus.imm          = im;
      scb.push_back(model(r, v, sb_in, s1, s2, x1, x2, p, im));
      tick(tag);
   endtask

   // Directed check of the current outputs against hand-derived constants.
   task automatic spot(input string tag, input logic [63:0] res, input logic [4:0] fl);
      chk({tag, "_spot_result"}, bus.result, res);
      chk({tag, "_spot_flags"}, 64'({bus.overflow, bus.sign, bus.cout, bus.carry, bus.zero}),
          64'(fl));
   endtask

   initial begin
      passed = 0;
      failed = 0;
      total  = 0;
      rst    = 1'b1;
      bus.in_valid = 1'b0; bus.sub = 1'b0; bus.alu_op1_src = 1'b0; bus.alu_op2_src = 2'b00;
      bus.rs1_data = '0; bus.rs2_data = '0; bus.pc = '0; bus.imm = '0;
      @(negedge clk);

      // Reset held with random inputs
      for (int i = 0; i < 2; i++) begin
         step("reset", 1'b1, 1'b1, 1'($urandom), 1'($urandom), 2'($urandom),
              {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom});
         spot("reset", 64'd0, 5'b00000);
      end

      // Add forwarding path, first post-reset sample
      step("add_fwd", 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 64'd5, 64'd7, 64'd0, 64'd0);
      spot("add_fwd", 64'd12, 5'b00000);

      // Operand select: pc + 4, pc + imm
      step("pc_plus4", 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 64'd99, 64'd77, 64'h8000_0000, 64'd0);
      spot("pc_plus4", 64'h8000_0004, 5'b00000);
      step("pc_imm", 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 64'd1, 64'd2, 64'h8000_0000,
           64'hFFFF_FFFF_FFFF_FFF8);
      spot("pc_imm", 64'h7FFF_FFF8, 5'b00110);
      step("zero_src", 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 64'h1234, 64'h55, 64'd0, 64'd9);

      // Subtract compares
      step("sub_3_5", 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 64'd3, 64'd5, 64'd0, 64'd0);
      spot("sub_3_5", 64'hFFFF_FFFF_FFFF_FFFE, 5'b01010);
      step("sub_eq", 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 64'h1234, 64'h1234, 64'd0, 64'd0);
      spot("sub_eq", 64'd0, 5'b00101);
      step("sub_min", 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 64'h8000_0000_0000_0000, 64'd1, 64'd0, 64'd0);
      spot("sub_min", 64'h7FFF_FFFF_FFFF_FFFF, 5'b10100);
      step("sub_0_1", 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 64'd0, 64'd1, 64'd0, 64'd0);
      spot("sub_0_1", 64'hFFFF_FFFF_FFFF_FFFF, 5'b01010);

      // Wrap and overflow on add
      step("wrap", 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0);
      spot("wrap", 64'd0, 5'b00111);
      step("add_ovf", 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0);
      spot("add_ovf", 64'h8000_0000_0000_0000, 5'b11000);

      // Back-to-back stream with reset on the third op
      step("b2b_0", 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 64'd100, 64'd23, 64'd0, 64'd0);
      step("b2b_1", 1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 64'd0, 64'd0, 64'h1000, 64'h10);
      step("b2b_rst", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 64'd40, 64'd2, 64'd0, 64'd0);
      spot("b2b_rst", 64'd0, 5'b00000);
      step("b2b_3", 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 64'd4, 64'd0, 64'd0, 64'd0);
      spot("b2b_3", 64'd0, 5'b00101);

      // Random operations against the model
      for (int i = 0; i < 16; i++) begin
         step("rand", 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
              {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom});
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
